// File: rtl/n64_cfg_mbox.sv
// n64_cfg_mbox: N64 <-> CPU configuration mailbox.
// The N64 side sees a 16-bit register window: status, command, FIFO count and
// DATA_WORDS 32-bit data registers split into halfwords, plus a version stamp.
// The N64 pushes commands into a small FIFO that the CPU drains. Overflow and
// command-error conditions are sticky and are cleared by write-1-to-clear.
module n64_cfg_mbox #(
    parameter int          DATA_WORDS = 4,
    parameter int          CMD_DEPTH  = 4,
    parameter logic [31:0] VERSION    = 32'h53437632,
    localparam int         AW         = $clog2(6 + 2*DATA_WORDS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     bus_request,
    input  logic                     bus_write,
    input  logic [AW:0]              bus_address,
    input  logic [15:0]              bus_wdata,
    output logic                     bus_ack,
    output logic [15:0]              bus_rdata,
    input  logic                     cpu_ready,
    output logic                     cpu_cmd_valid,
    output logic [7:0]               cpu_cmd,
    input  logic                     cpu_cmd_pop,
    input  logic                     cpu_done,
    input  logic                     cpu_error,
    input  logic [DATA_WORDS-1:0]    cpu_data_write,
    input  logic [31:0]              cpu_wdata,
    output logic [32*DATA_WORDS-1:0] cpu_data
);

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = $clog2(CMD_DEPTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] bus_idx;
    logic [7:0]    fifo_mem [CMD_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          in_progress;
    logic          cmd_error;
    logic          overflow;
    logic          bus_fire;
    logic          wr_fire;
    logic          sr_write;
    logic          push_req;
    logic          pop_ok;
    logic          do_push;
    logic          fifo_full;
    logic          busy;
    logic [15:0]   sr_value;
    logic [15:0]   read_mux;
    logic          addr_lsb_unused;

    // Halfword addressing: the byte lane bit carries no information.
    assign addr_lsb_unused = bus_address[0];
    assign bus_idx         = bus_address[AW:1];

    // An access is only accepted in IDLE; a request while acking is dropped.
    assign bus_fire  = (state == ST_IDLE) && bus_request;
    assign wr_fire   = bus_fire && bus_write;
    assign sr_write  = wr_fire && (bus_idx == AW'(0));
    assign push_req  = wr_fire && (bus_idx == AW'(1));
    assign fifo_full = (count == CW'(CMD_DEPTH));
    assign pop_ok    = cpu_cmd_pop && (count != '0);
    assign do_push   = push_req && (!fifo_full || pop_ok);

    assign cpu_cmd_valid = (count != '0);
    assign cpu_cmd       = fifo_mem[rd_ptr];
    assign busy          = cpu_cmd_valid | in_progress;
    assign sr_value      = {cpu_ready, busy, fifo_full, cmd_error, overflow, 11'b0};

    assign bus_ack   = (state == ST_WAIT);
    assign bus_rdata = bus_ack ? read_mux : 16'h0000;

    // Two-state handshake: accept in IDLE, ack for exactly one cycle in WAIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_request) begin
                        state <= ST_WAIT;
                        idx_q <= bus_idx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Command storage; a push into a full FIFO only lands when a pop frees a slot.
    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            fifo_mem[wr_ptr] <= bus_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !pop_ok) begin
                count <= count + CW'(1);
            end else if (!do_push && pop_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky status: a new pop restarts work, and setting an error beats clearing it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_progress <= 1'b0;
            cmd_error   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (pop_ok) begin
                in_progress <= 1'b1;
            end else if (cpu_done) begin
                in_progress <= 1'b0;
            end
            if (cpu_done && cpu_error) begin
                cmd_error <= 1'b1;
            end else if (sr_write && bus_wdata[12]) begin
                cmd_error <= 1'b0;
            end
            if (push_req && fifo_full && !pop_ok) begin
                overflow <= 1'b1;
            end else if (sr_write && bus_wdata[11]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Data registers: each half is written independently and the bus has priority over the CPU.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cpu_data <= '0;
        end else begin
            for (int i = 0; i < DATA_WORDS; i++) begin
                if (wr_fire && (int'(bus_idx) == 4 + 2*i)) begin
                    cpu_data[32*i+16 +: 16] <= bus_wdata;
                end else if (cpu_data_write[i]) begin
                    cpu_data[32*i+16 +: 16] <= cpu_wdata[31:16];
                end
                if (wr_fire && (int'(bus_idx) == 5 + 2*i)) begin
                    cpu_data[32*i +: 16] <= bus_wdata;
                end else if (cpu_data_write[i]) begin
                    cpu_data[32*i +: 16] <= cpu_wdata[15:0];
                end
            end
        end
    end

    // Read window decode for the halfword latched at request time; unmapped slots read 0.
    always_comb begin
        read_mux = 16'h0000;
        if (int'(idx_q) == 0) begin
            read_mux = sr_value;
        end else if (int'(idx_q) == 2) begin
            read_mux = 16'(count);
        end else if (int'(idx_q) == 4 + 2*DATA_WORDS) begin
            read_mux = VERSION[31:16];
        end else if (int'(idx_q) == 5 + 2*DATA_WORDS) begin
            read_mux = VERSION[15:0];
        end
        for (int i = 0; i < DATA_WORDS; i++) begin
            if (int'(idx_q) == 4 + 2*i) begin
                read_mux = cpu_data[32*i+16 +: 16];
            end
            if (int'(idx_q) == 5 + 2*i) begin
                read_mux = cpu_data[32*i +: 16];
            end
        end
    end

endmodule

// File: tb/tb_n64_cfg_mbox.sv
// tb_n64_cfg_mbox: directed scenarios plus randomized traffic for n64_cfg_mbox,
// checked against a queue/array reference model of the mailbox.
module tb_n64_cfg_mbox;

    localparam int          DATA_WORDS = 4;
    localparam int          CMD_DEPTH  = 4;
    localparam logic [31:0] VERSION    = 32'h53437632;
    localparam int          AW         = $clog2(6 + 2*DATA_WORDS);

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     bus_request;
    logic                     bus_write;
    logic [AW:0]              bus_address;
    logic [15:0]              bus_wdata;
    logic                     bus_ack;
    logic [15:0]              bus_rdata;
    logic                     cpu_ready;
    logic                     cpu_cmd_valid;
    logic [7:0]               cpu_cmd;
    logic                     cpu_cmd_pop;
    logic                     cpu_done;
    logic                     cpu_error;
    logic [DATA_WORDS-1:0]    cpu_data_write;
    logic [31:0]              cpu_wdata;
    logic [32*DATA_WORDS-1:0] cpu_data;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  mq [$];
    logic [31:0] m_data [DATA_WORDS];
    bit          m_inprog  = 1'b0;
    bit          m_err     = 1'b0;
    bit          m_ovf     = 1'b0;
    bit          m_ack     = 1'b0;
    bit          m_rd      = 1'b0;
    int          m_idx     = 0;
    bit          m_started = 1'b0;

    n64_cfg_mbox #(
        .DATA_WORDS(DATA_WORDS),
        .CMD_DEPTH (CMD_DEPTH),
        .VERSION   (VERSION)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus_request   (bus_request),
        .bus_write     (bus_write),
        .bus_address   (bus_address),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .cpu_ready     (cpu_ready),
        .cpu_cmd_valid (cpu_cmd_valid),
        .cpu_cmd       (cpu_cmd),
        .cpu_cmd_pop   (cpu_cmd_pop),
        .cpu_done      (cpu_done),
        .cpu_error     (cpu_error),
        .cpu_data_write(cpu_data_write),
        .cpu_wdata     (cpu_wdata),
        .cpu_data      (cpu_data)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read of halfword idx must return given the model state.
    function automatic logic [15:0] model_read(input int idx);
        logic [15:0] r;
        r = 16'h0000;
        if (idx == 0) begin
            r = {cpu_ready, (mq.size() != 0) || m_inprog, mq.size() == CMD_DEPTH, m_err, m_ovf, 11'b0};
        end else if (idx == 2) begin
            r = 16'(mq.size());
        end else if (idx >= 4 && idx < 4 + 2*DATA_WORDS) begin
            r = ((idx % 2) == 0) ? m_data[(idx-4)/2][31:16] : m_data[(idx-4)/2][15:0];
        end else if (idx == 4 + 2*DATA_WORDS) begin
            r = VERSION[31:16];
        end else if (idx == 5 + 2*DATA_WORDS) begin
            r = VERSION[15:0];
        end
        return r;
    endfunction

    // Reference model, advanced on every rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        bit go;
        bit was_full;
        bit popping;
        int widx;
        if (!reset_n) begin
            mq.delete();
            foreach (m_data[i]) m_data[i] = 32'h0;
            m_inprog  = 1'b0;
            m_err     = 1'b0;
            m_ovf     = 1'b0;
            m_ack     = 1'b0;
            m_rd      = 1'b0;
            m_started = 1'b1;
        end else begin
            go       = !m_ack && bus_request;
            widx     = int'(bus_address[AW:1]);
            was_full = (mq.size() == CMD_DEPTH);
            popping  = cpu_cmd_pop && (mq.size() != 0);
            foreach (m_data[i]) begin
                if (cpu_data_write[i]) m_data[i] = cpu_wdata;
            end
            if (popping) void'(mq.pop_front());
            if (popping) m_inprog = 1'b1;
            else if (cpu_done) m_inprog = 1'b0;
            if (go && bus_write) begin
                if (widx == 0) begin
                    if (bus_wdata[12]) m_err = 1'b0;
                    if (bus_wdata[11]) m_ovf = 1'b0;
                end else if (widx == 1) begin
                    if (was_full && !popping) m_ovf = 1'b1;
                    else mq.push_back(bus_wdata[7:0]);
                end else if (widx >= 4 && widx < 4 + 2*DATA_WORDS) begin
                    if ((widx % 2) == 0) m_data[(widx-4)/2][31:16] = bus_wdata;
                    else m_data[(widx-4)/2][15:0] = bus_wdata;
                end
            end
            if (cpu_done && cpu_error) m_err = 1'b1;
            m_ack = go;
            m_rd  = go && !bus_write;
            if (go) m_idx = widx;
        end
    end

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        if (m_started) begin
            check_output("ack", 32'(bus_ack), 32'(m_ack));
            if (!m_ack) begin
                check_output("rdata_idle", 32'(bus_rdata), 32'h0);
            end else if (m_rd && m_idx != 1 && m_idx != 3) begin
                check_output("rdata", 32'(bus_rdata), 32'(model_read(m_idx)));
            end
            check_output("cmd_valid", 32'(cpu_cmd_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) check_output("cmd_head", 32'(cpu_cmd), 32'(mq[0]));
            for (int i = 0; i < DATA_WORDS; i++) begin
                check_output("cpu_data", cpu_data[32*i +: 32], m_data[i]);
            end
        end
    end

    // Inputs change 2 ns after the rising edge, well clear of both edges.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus_request    = 1'b0;
        bus_write      = 1'b0;
        cpu_cmd_pop    = 1'b0;
        cpu_done       = 1'b0;
        cpu_error      = 1'b0;
        cpu_data_write = '0;
    endtask

    // One bus access from IDLE: ack is required right after the request edge.
    task automatic bus_access(input bit wr, input int idx, input logic [15:0] wd, output logic [15:0] rd);
        logic [AW-1:0] a;
        a           = AW'(idx);
        bus_request = 1'b1;
        bus_write   = wr;
        bus_address = {a, 1'($urandom_range(0, 1))};
        bus_wdata   = wd;
        step();
        idle_inputs();
        check_output("access_ack", 32'(bus_ack), 32'd1);
        rd = bus_rdata;
        step();
    endtask

    task automatic pop_cmd();
        cpu_cmd_pop = 1'b1;
        step();
        idle_inputs();
    endtask

    // One cycle of random traffic on every input, including rare resets.
    task automatic apply_stimulus();
        int idx;
        bit wr;
        wr  = 1'($urandom_range(0, 1));
        idx = $urandom_range(0, 15);
        if (wr && $urandom_range(0, 2) == 0) idx = 1;
        if (!wr && (idx == 1 || idx == 3)) idx = 0;
        reset_n     = ($urandom_range(0, 299) != 0);
        cpu_ready   = 1'($urandom_range(0, 1));
        bus_request = ($urandom_range(0, 2) == 0);
        bus_write   = wr;
        bus_address = {AW'(idx), 1'($urandom_range(0, 1))};
        bus_wdata   = 16'($urandom);
        cpu_cmd_pop = ($urandom_range(0, 3) == 0);
        cpu_done    = ($urandom_range(0, 5) == 0);
        cpu_error   = 1'($urandom_range(0, 1));
        for (int i = 0; i < DATA_WORDS; i++) cpu_data_write[i] = ($urandom_range(0, 7) == 0);
        cpu_wdata   = $urandom;
        step();
    endtask

    // Directed scenarios with hand-computed values, then randomized traffic.
    initial begin
        logic [15:0] rd;
        reset_n     = 1'b0;
        cpu_ready   = 1'b0;
        bus_address = '0;
        bus_wdata   = '0;
        cpu_wdata   = '0;
        idle_inputs();
        repeat (3) step();
        reset_n = 1'b1;
        step();

        check_output("reset_ack", 32'(bus_ack), 32'h0);
        check_output("reset_valid", 32'(cpu_cmd_valid), 32'h0);
        check_output("reset_data", cpu_data[31:0], 32'h0);

        bus_access(1'b0, 4 + 2*DATA_WORDS, 16'h0, rd);
        check_output("version_h", 32'(rd), 32'h5343);
        check_output("ack_after", 32'(bus_ack), 32'h0);
        check_output("rdata_after", 32'(bus_rdata), 32'h0);
        bus_access(1'b0, 5 + 2*DATA_WORDS, 16'h0, rd);
        check_output("version_l", 32'(rd), 32'h7632);

        bus_access(1'b1, 1, 16'h0011, rd);
        bus_access(1'b1, 1, 16'h0022, rd);
        bus_access(1'b0, 2, 16'h0, rd);
        check_output("count_two", 32'(rd), 32'd2);
        check_output("head_11", 32'(cpu_cmd), 32'h11);
        pop_cmd();
        check_output("head_22", 32'(cpu_cmd), 32'h22);
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("sr_busy", 32'(rd), 32'h4000);
        pop_cmd();
        cpu_done = 1'b1;
        step();
        idle_inputs();
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("sr_quiet", 32'(rd), 32'h0000);

        for (int k = 1; k <= 5; k++) bus_access(1'b1, 1, 16'(k), rd);
        bus_access(1'b0, 2, 16'h0, rd);
        check_output("count_full", 32'(rd), 32'd4);
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("sr_full_ovf", 32'(rd), 32'h6800);
        bus_access(1'b1, 0, 16'h0800, rd);
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("sr_ovf_clr", 32'(rd), 32'h6000);

        cpu_cmd_pop = 1'b1;
        bus_access(1'b1, 1, 16'h00AA, rd);
        bus_access(1'b0, 2, 16'h0, rd);
        check_output("count_pushpop", 32'(rd), 32'd4);
        check_output("head_02", 32'(cpu_cmd), 32'h02);
        repeat (3) pop_cmd();
        check_output("head_aa", 32'(cpu_cmd), 32'hAA);

        cpu_data_write = 4'b0010;
        cpu_wdata      = 32'h12345678;
        bus_access(1'b1, 7, 16'hBEEF, rd);
        check_output("data1_collide", cpu_data[63:32], 32'h1234BEEF);
        bus_access(1'b0, 6, 16'h0, rd);
        check_output("data1_h", 32'(rd), 32'h1234);

        cpu_done  = 1'b1;
        cpu_error = 1'b1;
        step();
        idle_inputs();
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("sr_error", 32'(rd), 32'h5000);
        cpu_done  = 1'b1;
        cpu_error = 1'b1;
        bus_access(1'b1, 0, 16'h1000, rd);
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("sr_set_wins", 32'(rd), 32'h5000);
        bus_access(1'b1, 0, 16'h1000, rd);
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("sr_err_clr", 32'(rd), 32'h4000);

        bus_request = 1'b1;
        bus_write   = 1'b0;
        bus_address = '0;
        reset_n     = 1'b0;
        step();
        idle_inputs();
        check_output("reset_no_ack", 32'(bus_ack), 32'h0);
        reset_n = 1'b1;
        step();
        check_output("reset_clr_valid", 32'(cpu_cmd_valid), 32'h0);
        check_output("reset_clr_data", cpu_data[63:32], 32'h0);
        bus_access(1'b0, 0, 16'h0, rd);
        check_output("reset_sr", 32'(rd), 32'h0000);

        $display("[TB] directed phase done, starting random traffic");
        for (int c = 0; c < 3000; c++) apply_stimulus();
        reset_n = 1'b1;
        idle_inputs();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
